// File: rtl/pcie_pkg.sv
// Shared types and default sizes for the PCIE VC pop arbiter.
// Optional build macro: PCIE_STRICT_PRIO_EN (fixed VC priority instead of round-robin).
package pcie_pkg;

  localparam int DEFAULT_DATA_WIDTH = 12;
  localparam int DEFAULT_NUM_CH     = 4;
  localparam int DEFAULT_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  typedef logic [1:0] vc_idx_t;

endpackage

// File: rtl/pcie_rr_arb4.sv
// Four-way combinational arbiter for the VC pop path.
// Default: round-robin, first requester after last_grant wins (cyclically).
// PCIE_STRICT_PRIO_EN: fixed priority VC0 > VC1 > VC2 > VC3, last_grant ignored.
module pcie_rr_arb4
  import pcie_pkg::*;
(
  input  logic [3:0] request,
  input  vc_idx_t    last_grant,
  output logic [3:0] grant,
  output vc_idx_t    grant_idx
);

  // Select the winning channel index; grant is zero when nobody requests.
  always_comb begin
    vc_idx_t cand;
    cand      = '0;
    grant_idx = '0;
`ifdef PCIE_STRICT_PRIO_EN
    // Scan from lowest priority up so the lowest-numbered requester is kept.
    for (int k = 3; k >= 0; k--) begin
      cand = vc_idx_t'(k);
      if (request[cand]) grant_idx = cand;
    end
`else
    // Scan from farthest to nearest after last_grant; the nearest requester wins.
    // Offset 4 wraps to last_grant itself, which therefore has the lowest priority.
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + vc_idx_t'(k);
      if (request[cand]) grant_idx = cand;
    end
`endif
    grant = (request != 4'b0000) ? (4'b0001 << grant_idx) : 4'b0000;
  end

endmodule

// File: rtl/pcie_vc_pop_arbiter.sv
// Consumer end of the four PCIE VC output FIFOs: pops non-empty FIFOs in
// round-robin order onto one registered valid/ready stream, counts words per
// VC and offers a req/idx counter readback.
// Optional build macro: PCIE_STRICT_PRIO_EN (fixed priority VC0 > VC1 > VC2 > VC3).
module pcie_vc_pop_arbiter
  import pcie_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_CH     = DEFAULT_NUM_CH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_CH-1:0]            pop,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [1:0]                   out_ch,
  input  logic                         out_ready,
  input  logic                         req,
  input  logic [2:0]                   idx,
  output logic                         cnt_valid,
  output logic [CNT_WIDTH-1:0]         cnt_data,
  output logic                         idle
);

  logic                        out_valid_reg;
  logic [DATA_WIDTH-1:0]       out_data_reg;
  vc_idx_t                     out_ch_reg;
  vc_idx_t                     rr_ptr_reg;
  logic                        cnt_valid_reg;
  logic [CNT_WIDTH-1:0]        cnt_data_reg;
  state_t                      state_reg;
  logic                        idle_reg;
  logic [NUM_CH-1:0]           grant;
  vc_idx_t                     grant_idx;
  logic                        load;
  logic [NUM_CH*CNT_WIDTH-1:0] count_flat;

  pcie_rr_arb4 u_arb (
    .request    (~fifo_empty),
    .last_grant (rr_ptr_reg),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // A new word can be taken whenever the output stage is empty or draining.
  assign load = (!out_valid_reg || out_ready) && (fifo_empty != {NUM_CH{1'b1}});
  assign pop  = (reset && load) ? grant : '0;

  // Per-channel word counters, flattened so the readback can index them.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] cnt_reg;

      // Count every pop of this channel; wraps naturally at 2^CNT_WIDTH.
      always_ff @(posedge clk) begin
        if (!reset) cnt_reg <= '0;
        else if (pop[gi]) cnt_reg <= cnt_reg + 1'b1;
      end

      assign count_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate

  // Output stage: capture the granted head word, or empty out after the last accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= 2'd3;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= fifo_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      out_ch_reg    <= grant_idx;
      rr_ptr_reg    <= grant_idx;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Counter readback; the counter array is sampled before this cycle's pop lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_valid_reg <= 1'b0;
      cnt_data_reg  <= '0;
    end else if (req) begin
      if (idx < 3'd4) begin
        cnt_valid_reg <= 1'b1;
        cnt_data_reg  <= count_flat[idx[1:0]*CNT_WIDTH +: CNT_WIDTH];
      end else begin
        cnt_valid_reg <= 1'b0;
        cnt_data_reg  <= '0;
      end
    end else begin
      cnt_valid_reg <= 1'b0;
    end
  end

  // Activity state machine with idle as its registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      idle_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            state_reg <= ACTIVE;
            idle_reg  <= 1'b0;
          end
        end
        ACTIVE, STALL: begin
          if (out_valid_reg && out_ready && (fifo_empty == {NUM_CH{1'b1}})) begin
            state_reg <= IDLE;
            idle_reg  <= 1'b1;
          end else if (out_valid_reg && !out_ready) begin
            state_reg <= STALL;
          end else begin
            state_reg <= ACTIVE;
          end
        end
        default: begin
          state_reg <= IDLE;
          idle_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign cnt_valid = cnt_valid_reg;
  assign cnt_data  = cnt_data_reg;
  assign idle      = idle_reg;

endmodule

// File: doc/pcie_vc_pop_arbiter.md
Name: pcie_vc_pop_arbiter

Overview:
- Consumer end of the four PCIE virtual-channel output FIFOs (VC0..VC3).
- Pops words from the non-empty FIFOs in round-robin order and serializes them onto one registered valid/ready output stream.
- Keeps a per-channel word counter that can be read back with the same req/idx handshake used on the write side.
- Sits between the VC FIFO bank and the downstream link/checker.

Parameters:
- DATA_WIDTH, 12, width of each FIFO word and of out_data.
- NUM_CH, 4, number of VC FIFOs. Fixed at 4; other values are unsupported.
- CNT_WIDTH, 5, width of each per-channel word counter and of cnt_data.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- fifo_empty  input  4  empty flag per VC FIFO; bit i = VC i.
- fifo_data  input  4*DATA_WIDTH  show-ahead head word per FIFO; VC i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- pop  output  4  one-hot or zero pop strobe; each asserted cycle consumes one word.
- out_valid  output  1  out_data holds a word.
- out_data  output  DATA_WIDTH  serialized word.
- out_ch  output  2  source VC of out_data.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- req  input  1  counter read request.
- idx  input  3  counter index; 0..3 are valid.
- cnt_valid  output  1  cnt_data is valid.
- cnt_data  output  CNT_WIDTH  counter readback value.
- idle  output  1  all FIFOs are empty and the output stage is empty.

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, out_data=0, out_ch=0, cnt_valid=0, cnt_data=0, all counters=0, rr pointer=3 (so VC0 wins first), state=IDLE.
- pop is combinational and is forced to 0 while reset==0.
- Mid-operation reset discards the word in the output stage. FIFOs are not popped during reset.
- Load condition: load = (!out_valid || out_ready) && (fifo_empty != 4'b1111).
- Grant: the first non-empty VC after the rr pointer, cyclically. On load, pop[grant]=1, out_data<=fifo_data[grant], out_ch<=grant, out_valid<=1, and the rr pointer<=grant.
- If out_valid && out_ready && no channel is non-empty, out_valid<=0 and out_data holds its value.
- Latency: a word at a FIFO head reaches out_valid one cycle after pop. Back-to-back throughput is 1 word/cycle while out_ready=1.
- The output is stable while out_valid && !out_ready; pop=0 during a stall.
- State machine (observable through idle):
  - IDLE: out_valid=0 and all FIFOs empty; idle=1. Goes to ACTIVE on load.
  - ACTIVE: word presented and moving. Goes to STALL on out_valid && !out_ready. Goes to IDLE when the last word is accepted and all FIFOs are empty.
  - STALL: goes back to ACTIVE on out_ready.
- Counters:
  - count[grant] increments by 1 on each pop; it wraps modulo 2^CNT_WIDTH (31 -> 0).
  - Counters are cleared only by reset.
- Readback:
  - req=1 with idx<4: next cycle cnt_valid=1 and cnt_data=count[idx], using the pre-increment value if a pop to that VC happens in the same cycle.
  - req=1 with idx>=4: cnt_valid=0 and cnt_data=0.
  - req=0: cnt_valid=0 and cnt_data holds its value.
- A fifo_empty bit that changes in the same cycle as a pop only matters for the next grant; pop never targets a VC whose fifo_empty bit is currently 1.

Optional Feature:
- Macro: PCIE_STRICT_PRIO_EN.
- Defined: fixed priority VC0 > VC1 > VC2 > VC3. The rr pointer is unused, and a persistently non-empty VC0 starves the others.
- Undefined: round-robin arbitration as described above.

Decomposition:
- Package pcie_pkg holds:
  - DATA_WIDTH, NUM_CH and CNT_WIDTH defaults;
  - the state enum {IDLE, ACTIVE, STALL}, 2-bit;
  - the VC index typedef, 2-bit.
- One sub-module, pcie_rr_arb4. It is purely combinational: 4-bit request plus 2-bit last-grant in, one-hot grant and 2-bit index out. The strict-priority mux inside it sits under the macro.

Test Plan:
- Reset: hold reset=0 for 2 cycles with FIFOs non-empty -> pop=0, out_valid=0, counters read back 0, idle=1 once FIFOs are empty.
- Round-robin: all four FIFOs non-empty with heads 0x0A4/0x415/0x8A5/0xC8D and out_ready=1 -> out_ch sequence 0,1,2,3,0; out_data follows the head values; one pop per cycle.
- Stall: out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_ch stable, pop=0; on out_ready=1, the next grant resumes in round-robin order.
- Single channel: only VC2 non-empty with 5 words -> 5 consecutive pops of VC2; then req=1, idx=2 -> cnt_valid=1 and cnt_data=5; idx=4 -> cnt_valid=0.
- Wrap and simultaneous events: pop 33 words from VC1 -> counter reads 1. A req for idx=1 issued in the same cycle as a pop returns the pre-increment value.
- Mid-reset: assert reset=0 while STALL holds a word -> out_valid=0 the next cycle and counters=0; with PCIE_STRICT_PRIO_EN defined and VC0 and VC3 both non-empty, only VC0 is granted until it is empty.
